// File: rtl/div_pkg.sv
`default_nettype none
// div_pkg: shared widths, FSM encoding and divide-by-zero constant for the divider scheduler.
// Rev 1.0
package div_pkg;
   localparam int DIVIDEND_W = 8;
   localparam int DIVISOR_W  = 4;
   localparam int ITER       = 8;
   localparam int ID_W       = 2;

   localparam logic [DIVIDEND_W-1:0] DIV0_Q = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage
`default_nettype wire

// File: rtl/div_core.sv
`default_nettype none
// div_core: sequential 8-by-4 restoring divider, one quotient bit per step, MSB first.
// Rev 1.0
module div_core
   import div_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  step,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  last
);
   logic [DIVIDEND_W-1:0] dvd_sh;
   logic [DIVIDEND_W-1:0] q;
   logic [DIVISOR_W-1:0]  dvs;
   logic [DIVISOR_W:0]    p;
   logic [DIVISOR_W:0]    p_shift;
   logic [DIVISOR_W:0]    p_next;
   logic [2:0]            cnt;
   logic                  qbit;

   always_comb begin
      p_shift = {p[DIVISOR_W-1:0], dvd_sh[DIVIDEND_W-1]};
      qbit    = (p_shift >= {1'b0, dvs});
      p_next  = qbit ? (p_shift - {1'b0, dvs}) : p_shift;
   end

   // Results include the step in progress, so they are final in the cycle 'last' is high.
   assign quotient  = {q[DIVIDEND_W-2:0], qbit};
   assign remainder = p_next[DIVISOR_W-1:0];
   assign last      = step && (cnt == 3'(ITER - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_sh <= '0;
         dvs    <= '0;
         p      <= '0;
         q      <= '0;
         cnt    <= '0;
      end else if (load) begin
         dvd_sh <= dividend;
         dvs    <= divisor;
         p      <= '0;
         q      <= '0;
         cnt    <= '0;
      end else if (step) begin
         dvd_sh <= dvd_sh << 1;
         p      <= p_next;
         q      <= quotient;
         cnt    <= cnt + 3'd1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/div_sched.sv
`default_nettype none
// div_sched: round-robin scheduler sharing one div_core between N_REQ requesters.
// Rev 1.0
module div_sched
   import div_pkg::*;
#(
   parameter int N_REQ = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [DIVIDEND_W*N_REQ-1:0] req_dividend,
   input  logic [DIVISOR_W*N_REQ-1:0]  req_divisor,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DIVIDEND_W-1:0]     rsp_quotient,
   output logic [DIVISOR_W-1:0]      rsp_remainder,
   output logic                      rsp_err,
   input  logic                      rsp_ready,
   output logic                      busy
);
   state_t                state, state_nxt;
   logic [ID_W-1:0]       ptr, ptr_nxt, win_id;
   logic [N_REQ-1:0]      rot, grant;
   logic                  win_found, accept, load, step;
   logic [DIVIDEND_W-1:0] sel_dvd, core_q;
   logic [DIVISOR_W-1:0]  sel_dvs, core_r;
   logic                  core_last;
   int                    off, sum, nxt;

   // Rotate so the pointer lands on bit 0; the first set bit is the winner's offset.
   always_comb begin
      rot       = N_REQ'({req_valid, req_valid} >> ptr);
      win_found = 1'b0;
      off       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!win_found && rot[k]) begin
            win_found = 1'b1;
            off       = k;
         end
      end
      sum = int'(ptr) + off;
      if (sum >= N_REQ) sum = sum - N_REQ;
      win_id = ID_W'(sum);
      nxt    = sum + 1;
      if (nxt >= N_REQ) nxt = 0;
      ptr_nxt = ID_W'(nxt);
      grant   = '0;
      sel_dvd = '0;
      sel_dvs = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_found && (win_id == ID_W'(i))) begin
            grant[i] = 1'b1;
            sel_dvd  = req_dividend[DIVIDEND_W*i +: DIVIDEND_W];
            sel_dvs  = req_divisor[DIVISOR_W*i +: DIVISOR_W];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (win_found) begin
               accept = 1'b1;
               if (sel_dvs != '0) begin
                  load      = 1'b1;
                  state_nxt = RUN;
               end else begin
                  state_nxt = RESP;
               end
            end
         end
         RUN: begin
            step = 1'b1;
            if (core_last) state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr           <= '0;
         rsp_id        <= '0;
         rsp_quotient  <= '0;
         rsp_remainder <= '0;
         rsp_err       <= 1'b0;
      end else begin
         if (accept) begin
            ptr    <= ptr_nxt;
            rsp_id <= win_id;
            if (sel_dvs == '0) begin
               rsp_quotient  <= DIV0_Q;
               rsp_remainder <= sel_dvd[DIVISOR_W-1:0];
               rsp_err       <= 1'b1;
            end
         end
         if (step && core_last) begin
            rsp_quotient  <= core_q;
            rsp_remainder <= core_r;
            rsp_err       <= 1'b0;
         end
      end
   end

   // Gated by rst_n so no grant is offered while reset is held.
   assign req_ready = (state == IDLE && rst_n) ? grant : '0;
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   div_core u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .step      (step),
      .dividend  (sel_dvd),
      .divisor   (sel_dvs),
      .quotient  (core_q),
      .remainder (core_r),
      .last      (core_last)
   );
endmodule
`default_nettype wire

// File: doc/div_sched.md
# div_sched

Scheduler that shares one sequential 8-bit by 4-bit restoring divider between `N_REQ` requesters. It sits between the switch/button front-ends and the divider datapath and arbitrates requests round-robin. It captures the winner's operands, sequences the divider for eight iterations, and returns the quotient and remainder on a single tagged response channel with valid/ready back-pressure. Divide-by-zero is detected at grant and answered without running the divider.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 1..4.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  `N_REQ`: requester i presents an operation.
- `req_dividend`  in  `8*N_REQ`: dividend of requester i in slice `[8i+7:8i]`.
- `req_divisor`  in  `4*N_REQ`: divisor of requester i in slice `[4i+3:4i]`.
- `req_ready`  out  `N_REQ`: one-hot grant; operands are accepted on the edge where `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  1: response available.
- `rsp_id`  out  2: index of the requester being answered.
- `rsp_quotient`  out  8: quotient.
- `rsp_remainder`  out  4: remainder.
- `rsp_err`  out  1: the divisor was zero.
- `rsp_ready`  in  1: the consumer takes the response.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: `req_ready` = the round-robin one-hot winner among `req_valid`, driven combinationally. With no valid request it stays in IDLE.
  - Accept edge with a nonzero divisor: capture operands and id, clear the iteration counter, go to RUN.
  - Accept edge with a zero divisor: load `rsp_quotient`=8'hFF, `rsp_remainder`=dividend[3:0], `rsp_err`=1, go to RESP.
  - RUN: one quotient bit per cycle, MSB first. After 8 iterations go to RESP with `rsp_err`=0.
  - RESP: `rsp_valid`=1 and all response fields held stable. On the edge with `rsp_ready`=1 go to IDLE.
- Iteration (restoring division):
  - Partial remainder register is 5 bits wide.
  - Each step: p = {p[3:0], next dividend bit}.
  - If p >= {1'b0, divisor}: p = p - divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - The final p[3:0] is the remainder. No overflow is possible: quotient fits in 8 bits, remainder < divisor.
- Round-robin:
  - Pointer is the last granted index plus 1, modulo `N_REQ`.
  - Search starts at the pointer and takes the first valid index.
  - The pointer updates only on an accept edge.
- Requester rules:
  - Operands must stay stable while `req_valid` is high and not yet accepted.
  - Dropping `req_valid` before acceptance is legal and has no effect.
  - `req_ready` is 0 in every state except IDLE.
- Reset values: state IDLE, pointer 0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_quotient`=0, `rsp_remainder`=0, `rsp_err`=0, `busy`=0.
- Reset mid-operation: the in-flight operation is discarded and no response is produced. After reset release, the first grant goes to the lowest valid index.

## Timing
- Accept edge E0. Nonzero divisor: RUN iterations on edges E1..E8, `rsp_valid` high starting after E8. Minimum latency is 8 cycles from acceptance to `rsp_valid`.
- Zero divisor: `rsp_valid` high starting right after E0 (1 cycle).
- Response handshake edge H moves the FSM to IDLE. The next grant can occur on edge H+1, so sustained throughput is one operation per 10 cycles.
- A held-low `rsp_ready` stalls indefinitely. New `req_valid` assertions during the stall wait; no request is lost or reordered.
- `busy` rises after E0 and falls after H.

## Structure
- Shared package `div_pkg` holds:
  - `DIVIDEND_W`=8, `DIVISOR_W`=4, `ITER`=8, `ID_W`=2.
  - State enum: IDLE, RUN, RESP.
  - Divide-by-zero constant `DIV0_Q`=8'hFF.
- Sub-module `div_core` implements the iteration datapath: dividend shift register, 5-bit partial remainder, quotient register, 3-bit iteration counter.
  - Inputs: `load`, `step`, operands.
  - Output: `last` on the 8th step.
  - `div_sched` contains the arbiter, the FSM and the response registers.

## Test plan
- Requester 0 sends 200/7 → after 8 cycles `rsp_valid`=1, `rsp_id`=0, `rsp_quotient`=28, `rsp_remainder`=4, `rsp_err`=0.
- Requester 1 sends 255/1 and then 0/15 → responses 255 r0 and 0 r0, each 8 cycles after its accept.
- Requester 0 sends 13/0 → `rsp_valid` one cycle after accept, `rsp_quotient`=8'hFF, `rsp_remainder`=4'hD, `rsp_err`=1.
- Both requesters hold valid continuously from reset release → grant order 0,1,0,1. Each response carries the matching id and the correct result.
- `rsp_ready` held low for 20 cycles while requester 1 is valid → response fields stable, `req_ready` stays 0, requester 1 is granted on the cycle after the handshake.
- `rst_n` pulsed low during RUN (after E4) → all outputs return to reset values immediately, no `rsp_valid`, next request completes correctly.
